ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver, fully synchronous to the system clock.
- Oversamples the PS/2 clock and data lines and glitch-filters them.
- Decodes 11-bit frames with parity, stop-bit and timeout checking.
- Collapses scan-code-set-2 prefixes (E0 extended, F0 break) into single key events.
- Buffers events in a FIFO with a valid/ready handshake.
- Sits between the PS/2 connector pins and the keyboard consumer logic.

Parameters:
FILTER_LEN, 8, consecutive equal samples required before the filtered ps2_clk/ps2_data changes (range 2..255).
TIMEOUT_CYC, 100000, clk cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted.
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  reset, asynchronous, active-low.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
ps2_data  input  1  raw PS/2 data pin, asynchronous.
ev_valid  output  1  FIFO non-empty; the head event is presented.
ev_ready  input  1  consumer accepts the head event when ev_valid && ev_ready.
ev_code  output  8  scan code of the head event.
ev_break  output  1  1 = key release (F0 seen), 0 = key press.
ev_ext  output  1  1 = extended key (E0 seen).
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored events.
frame_err  output  1  one-cycle pulse on parity error, bad stop bit or timeout.
overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
Reset (rst=0, asynchronous):
- All state clears; the FSM goes to IDLE.
- Synchronisers and filtered lines are set to 1; the filter counters clear.
- Prefix flags clear and the FIFO empties.
- Outputs: ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, fifo_level=0, frame_err=0, overflow=0.
- Reset mid-frame discards the partial byte and any pending prefixes.

Input conditioning:
- Two-flop synchroniser on each line.
- A filtered line takes the synchronised value only after FILTER_LEN consecutive equal samples.
- A filtered-clock 1->0 transition is one "fall" event, a single-cycle strobe; data is sampled from filtered ps2_data on that strobe.

Frame FSM (advances only on fall strobes, except timeout):
- IDLE: data=0 -> DATA with bit count 0. data=1 -> stay IDLE, no error.
- DATA: shift bits in LSB first; after the 8th bit -> PARITY.
- PARITY: store the parity bit -> STOP.
- STOP: stop=1 and odd parity over data+parity -> byte valid, strobe into the decoder. Otherwise pulse frame_err and discard the byte. Either way -> IDLE.
- Timeout: a watchdog clears on every fall strobe and counts while not in IDLE. When it reaches TIMEOUT_CYC: -> IDLE, pulse frame_err, discard the partial byte.

Prefix decoder (acts on each valid byte):
- E0 -> ext_pend=1.
- F0 -> brk_pend=1.
- Any other byte, including E1/AA/FA/EE -> push {ext_pend, brk_pend, byte}, then clear both flags.
- frame_err also clears both flags.

Push latency:
- Push happens on the cycle after the STOP-bit fall strobe.
- ev_valid rises on the next cycle if the FIFO was empty.

FIFO:
- First-word-fall-through.
- Head outputs are held stable while ev_valid && !ev_ready.
- Pop on ev_valid && ev_ready.
- A push is accepted when not full, or when full with a pop in the same cycle (level unchanged).
- A push to a full FIFO with no pop drops the new event, pulses overflow, and leaves contents unchanged.
- Pop when empty has no effect.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro: PS2_TYPEMATIC_FILTER_EN.
With the macro defined:
- A held register {valid, ext, code} tracks the last make event pushed.
- A make event equal to the held key ({ext, code} match) is suppressed: no push and no overflow.
- A break event for the held key clears valid and is pushed.
- Any other make event is pushed and becomes the held key.
- Other break events are pushed without changing the register.
- Reset and frame_err clear valid.

Without the macro: every decoded event is pushed; no extra registers.

Test Plan:
1. Frame 0x1C (odd parity bit=0, stop=1) at a 40 us PS/2 period, 50 MHz clk -> one event code=1C break=0 ext=0; fifo_level=1; ev_valid rises 2 clks after the filtered stop fall.
2. Bytes E0,F0,75 -> exactly one event code=75 ext=1 break=1. Then byte 75 -> code=75 ext=0 break=0.
3. Frame 0x1C with parity bit flipped -> frame_err pulses 1 cycle, no event. Stop bit=0 -> same. Frame truncated after 4 bits with the line idle for TIMEOUT_CYC -> frame_err, FSM in IDLE, and the next good frame decodes correctly.
4. Hold ev_ready=0; send FIFO_DEPTH+1 make codes -> fifo_level=FIFO_DEPTH, one overflow pulse, and the first FIFO_DEPTH codes drain in order. At full, a push coinciding with a pop -> accepted, level stays FIFO_DEPTH.
5. 2-cycle glitches on ps2_clk with FILTER_LEN=8 -> no bit sampled. Reset asserted mid-frame and after F0 -> outputs clear, and the next byte 1C decodes as a make.
6. Macro defined: 1C,1C,1C,F0,1C -> events make 1C then break 1C only. Macro undefined -> 4 events.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin conditioning, frame decode, set-2 prefix collapse, event FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated make codes of the currently held key.
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic [7:0]                      ev_code,
  output logic                            ev_break,
  output logic                            ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------
  // Input conditioning: bit 0 = ps2_clk, bit 1 = ps2_data
  // ---------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] filt;

  assign raw_in = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cond
      logic       sync1_reg;
      logic       sync2_reg;
      logic       line_reg;
      logic [7:0] cnt_reg;

      // The counter only runs while the synchronised value disagrees with the filtered one.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          line_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == line_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == 8'(FILTER_LEN - 1)) begin
            cnt_reg  <= '0;
            line_reg <= sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      end

      assign filt[gi] = line_reg;
    end
  endgenerate

  logic clk_f_prev_reg;
  logic fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) clk_f_prev_reg <= 1'b1;
    else      clk_f_prev_reg <= filt[0];
  end

  assign fall = clk_f_prev_reg & ~filt[0];

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          par_reg;
  logic [TW-1:0] wd_reg;
  logic          byte_valid_reg;
  logic          frame_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_reg        <= 1'b0;
      wd_reg         <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (fall) begin
        wd_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (!filt[1]) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg   <= {filt[1], shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            par_reg   <= filt[1];
            state_reg <= STOP;
          end
          STOP: begin
            if (filt[1] && (^{shift_reg, par_reg})) byte_valid_reg <= 1'b1;
            else                                   frame_err_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg != IDLE) begin
        // Watchdog: a stalled frame is abandoned so the next start bit is seen cleanly.
        if (wd_reg == TW'(TIMEOUT_CYC - 1)) begin
          wd_reg        <= '0;
          state_reg     <= IDLE;
          frame_err_reg <= 1'b1;
        end else begin
          wd_reg <= wd_reg + TW'(1);
        end
      end else begin
        wd_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------
  logic       ext_pend_reg;
  logic       brk_pend_reg;
  logic       is_prefix;
  logic       push_req;
  logic [9:0] push_data;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_valid_reg;
  logic       held_ext_reg;
  logic [7:0] held_code_reg;
  logic       held_match;

  assign held_match = held_valid_reg && (held_ext_reg == ext_pend_reg) &&
                      (held_code_reg == shift_reg);
`endif

  assign push_data = {ext_pend_reg, brk_pend_reg, shift_reg};

  always_comb begin
    is_prefix = (shift_reg == 8'hE0) || (shift_reg == 8'hF0);
    push_req  = byte_valid_reg && !is_prefix;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (push_req && !brk_pend_reg && held_match) push_req = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend_reg <= 1'b0;
      brk_pend_reg <= 1'b0;
    end else if (frame_err_reg) begin
      ext_pend_reg <= 1'b0;
      brk_pend_reg <= 1'b0;
    end else if (byte_valid_reg) begin
      if (shift_reg == 8'hE0) begin
        ext_pend_reg <= 1'b1;
      end else if (shift_reg == 8'hF0) begin
        brk_pend_reg <= 1'b1;
      end else begin
        ext_pend_reg <= 1'b0;
        brk_pend_reg <= 1'b0;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_valid_reg <= 1'b0;
      held_ext_reg   <= 1'b0;
      held_code_reg  <= '0;
    end else if (frame_err_reg) begin
      held_valid_reg <= 1'b0;
    end else if (push_req) begin
      if (brk_pend_reg) begin
        if (held_match) held_valid_reg <= 1'b0;
      end else begin
        held_valid_reg <= 1'b1;
        held_ext_reg   <= ext_pend_reg;
        held_code_reg  <= shift_reg;
      end
    end
  end
`endif

  // ---------------------------------------------------------------
  // Event FIFO: storage array plus a registered head word
  // ---------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          overflow_reg;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign full    = (level_reg == LW'(FIFO_DEPTH));
  assign do_pop  = ev_valid && ev_ready;
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push_req && full && !do_pop;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      level_reg <= level_reg + LW'(1);
      else if (!do_push && do_pop) level_reg <= level_reg - LW'(1);
      // The new word bypasses the array when it becomes the head immediately.
      if (do_push && ((level_reg == '0) || (do_pop && level_reg == LW'(1))))
        head_reg <= push_data;
      else if (do_pop && level_reg > LW'(1))
        head_reg <= mem[rd_ptr_reg + AW'(1)];
    end
  end

  assign ev_valid   = (level_reg != '0);
  assign ev_code    = head_reg[7:0];
  assign ev_break   = head_reg[8];
  assign ev_ext     = head_reg[9];
  assign fifo_level = level_reg;
  assign frame_err  = frame_err_reg;
  assign overflow   = overflow_reg;

endmodule
